// File: rtl/s27_bist_pkg.sv
// rtl/s27_bist_pkg.sv - shared types, widths and step functions for the s27 BIST driver
package s27_bist_pkg;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    localparam int LFSR_W = 8;
    localparam int SIG_W  = 16;
    localparam int CNT_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;

    // Fibonacci shift-left step; the tap mask selects q[7], q[5], q[4], q[3].
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    // One serial CRC-16-CCITT step folding in a single response bit.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic d);
        return {s[SIG_W-2:0], 1'b0} ^ ((s[SIG_W-1] ^ d) ? MISR_POLY : '0);
    endfunction

endpackage

// File: rtl/s27_bist_driver_if.sv
// rtl/s27_bist_driver_if.sv - control/status bundle between a test controller and the BIST driver
interface s27_bist_driver_if import s27_bist_pkg::*;;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;

    modport master (output start, input busy, input done, input pass, input signature);
    modport slave  (input start, output busy, output done, output pass, output signature);
endinterface

// File: rtl/s27_misr.sv
// rtl/s27_misr.sv - 16-bit serial MISR with synchronous clear and capture enable
module s27_misr import s27_bist_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    // Clear wins over capture so a restart never folds in a stale response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/s27_bist_driver.sv
// rtl/s27_bist_driver.sv - LFSR stimulus / MISR response driver for s27; S27_BIST_COMPARE_EN adds the pass comparator
module s27_bist_driver import s27_bist_pkg::*; #(
    parameter int                INIT_CYCLES   = 4,
    parameter logic [3:0]        INIT_VEC      = 4'b0000,
    parameter int                PATTERN_COUNT = 64,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'h01
`ifdef S27_BIST_COMPARE_EN
    ,
    parameter logic [SIG_W-1:0]  EXP_SIG       = 16'h0000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    s27_bist_driver_if.slave   ctl,
    output logic               g0_o,
    output logic               g1_o,
    output logic               g2_o,
    output logic               g3_o,
    input  logic               g17_i
);

    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(PATTERN_COUNT - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
    localparam logic [3:0]       FIRST_VEC = (INIT_CYCLES == 0) ? LFSR_SEED[3:0] : INIT_VEC;
    localparam state_t           FIRST_ST  = (INIT_CYCLES == 0) ? RUN : INIT;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  init_cnt;
    logic [3:0]        vec;
    logic              busy_q;
    logic              done_q;
    logic              start_ok;
    logic              misr_en;
    logic [SIG_W-1:0]  sig;

    assign lfsr_nxt = lfsr_step(lfsr);
    assign start_ok = ctl.start && ((state == IDLE) || (state == DONE));
    assign misr_en  = (state == RUN);

    s27_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (misr_en),
        .din   (g17_i),
        .sig   (sig)
    );

`ifdef S27_BIST_COMPARE_EN
    logic pass_q;

    // Verdict is latched from the final MISR value on DONE entry and dropped on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (start_ok) begin
            pass_q <= 1'b0;
        end else if ((state == RUN) && (run_cnt == RUN_LAST)) begin
            pass_q <= (misr_step(sig, g17_i) == EXP_SIG);
        end
    end

    assign ctl.pass = pass_q;
`else
    assign ctl.pass = 1'b0;
`endif

    // Sequencer: IDLE/DONE wait for start, INIT flushes the DUT, RUN streams LFSR vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= LFSR_SEED;
            run_cnt  <= '0;
            init_cnt <= '0;
            vec      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ctl.start) begin
                        state    <= FIRST_ST;
                        lfsr     <= LFSR_SEED;
                        run_cnt  <= '0;
                        init_cnt <= '0;
                        vec      <= FIRST_VEC;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state <= RUN;
                        vec   <= lfsr[3:0];
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_nxt;
                    if (run_cnt == RUN_LAST) begin
                        // Last capture: hold the final vector and stop counting so the counter never wraps.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                        vec     <= lfsr_nxt[3:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign g0_o          = vec[0];
    assign g1_o          = vec[1];
    assign g2_o          = vec[2];
    assign g3_o          = vec[3];
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.signature = sig;

endmodule

// File: tb/tb_s27_bist_driver.sv
// tb/tb_s27_bist_driver.sv - self-checking bench for s27_bist_driver against an s27 netlist model
module tb_s27_bist_driver;

    // s27 netlist: returns {G17, next G7, next G6, next G5}; st = {G7, G6, G5}.
    function automatic logic [3:0] s27_eval(input logic [3:0] v, input logic [2:0] st);
        logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g14 = ~v[0];
        g8  = g14 & st[1];
        g12 = ~(v[1] | st[2]);
        g15 = g12 | g8;
        g16 = v[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[0] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(v[2] | g12);
        return {~g11, g13, g11, g10};
    endfunction

    // CRC-16-CCITT as polynomial long division of one appended bit.
    function automatic logic [15:0] crc_bit(input logic [15:0] s, input logic b);
        logic [16:0] r;
        r = {s, 1'b0} ^ {b, 16'h0000};
        if (r[16]) r = r ^ 17'h11021;
        return r[15:0];
    endfunction

    // Feedback bit is the parity of q over tap positions 7,5,4,3.
    function automatic logic [7:0] lfsr_adv(input logic [7:0] q);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (((8'hB8 >> i) & 8'h01) != 0 && q[i]) ones++;
        return {q[6:0], ones[0]};
    endfunction

    // Expected signature of one full run from a flushed s27; flip selects one corrupted capture.
    function automatic logic [15:0] golden_sig(input int n, input int flip);
        logic [2:0]  st;
        logic [7:0]  q;
        logic [15:0] s;
        logic [3:0]  ev;
        st = 3'b000;
        q  = 8'h01;
        s  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            ev = s27_eval(4'b0000, st);
            st = ev[2:0];
        end
        for (int k = 0; k < n; k++) begin
            ev = s27_eval(q[3:0], st);
            s  = crc_bit(s, ev[3] ^ (k == flip));
            st = ev[2:0];
            q  = lfsr_adv(q);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLDEN = golden_sig(64, -1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic model_rst_n;
    logic flip_a;
    logic g17_b;
    logic g17_c;
    logic ga0, ga1, ga2, ga3, g17_a;
    logic gb0, gb1, gb2, gb3;
    logic gc0, gc1, gc2, gc3;
    logic [2:0] st;
    logic [3:0] ev;
    int checks = 0;
    int errors = 0;

    s27_bist_driver_if ia ();
    s27_bist_driver_if ib ();
    s27_bist_driver_if ic ();

    s27_bist_driver #(
        .INIT_CYCLES   (4),
        .PATTERN_COUNT (64)
`ifdef S27_BIST_COMPARE_EN
        ,
        .EXP_SIG       (GOLDEN)
`endif
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ia),
        .g0_o  (ga0),
        .g1_o  (ga1),
        .g2_o  (ga2),
        .g3_o  (ga3),
        .g17_i (g17_a)
    );

    s27_bist_driver #(.INIT_CYCLES(0), .PATTERN_COUNT(5)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ib),
        .g0_o  (gb0),
        .g1_o  (gb1),
        .g2_o  (gb2),
        .g3_o  (gb3),
        .g17_i (g17_b)
    );

    s27_bist_driver #(.INIT_CYCLES(0), .PATTERN_COUNT(1)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ic),
        .g0_o  (gc0),
        .g1_o  (gc1),
        .g2_o  (gc2),
        .g3_o  (gc3),
        .g17_i (g17_c)
    );

    // Behavioural s27 hanging off the main driver.
    assign ev    = s27_eval({ga3, ga2, ga1, ga0}, st);
    assign g17_a = ev[3] ^ flip_a;

    always_ff @(posedge clk or negedge model_rst_n) begin
        if (!model_rst_n) st <= 3'b000;
        else              st <= ev[2:0];
    end

    function automatic logic exp_pass(input logic [15:0] s);
`ifdef S27_BIST_COMPARE_EN
        return s == GOLDEN;
`else
        return (s == 16'hFFFF) && (s != 16'hFFFF);
`endif
    endfunction

    task automatic launch_a(input bit hold);
        @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        checks++;
        if (ia.busy !== 1'b1) begin
            errors++;
            $display("FAIL launch_busy got=%0b want=1", ia.busy);
        end
        model_rst_n = 1'b0;
        if (!hold) ia.start = 1'b0;
        @(negedge clk);
        model_rst_n = 1'b1;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while (ia.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ia.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout got=%0b want=1", ia.done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        model_rst_n = 1'b0;
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        flip_a = 1'b0; g17_b = 1'b0; g17_c = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ia.busy, ia.done, ia.pass, ia.signature, ga3, ga2, ga1, ga0} !== 23'h0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", {ia.busy, ia.done, ia.pass, ia.signature, ga3, ga2, ga1, ga0});
        end
        rst_n = 1'b1;
        model_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ia.busy, ia.done, ia.pass, ia.signature, ga3, ga2, ga1, ga0,
                 ib.busy, ib.done, ib.signature, gb3, gb2, gb1, gb0} !== 45'h0) begin
                errors++;
                $display("FAIL idle_hold cycle=%0d a_sig=%h b_sig=%h want all 0", i, ia.signature, ib.signature);
            end
        end
    endtask

    task automatic test_lfsr_sequence;
        logic [7:0] q;
        q = 8'h01;
        @(negedge clk);
        ib.start = 1'b1;
        g17_b = 1'b0;
        @(negedge clk);
        ib.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({gb3, gb2, gb1, gb0} !== q[3:0] || ib.busy !== 1'b1) begin
                errors++;
                $display("FAIL lfsr_vec k=%0d got=%h busy=%0b want=%h busy=1", k, {gb3, gb2, gb1, gb0}, ib.busy, q[3:0]);
            end
            if (k < 4) q = lfsr_adv(q);
            @(negedge clk);
        end
        checks++;
        if (ib.done !== 1'b1 || ib.busy !== 1'b0 || ib.signature !== 16'h0000 || {gb3, gb2, gb1, gb0} !== q[3:0]) begin
            errors++;
            $display("FAIL lfsr_done done=%0b busy=%0b sig=%h vec=%h want 1 0 0000 %h",
                     ib.done, ib.busy, ib.signature, {gb3, gb2, gb1, gb0}, q[3:0]);
        end
    endtask

    task automatic test_misr_random;
        logic [15:0] s;
        for (int r = 0; r < 3; r++) begin
            s = 16'h0000;
            @(negedge clk);
            ib.start = 1'b1;
            @(negedge clk);
            ib.start = 1'b0;
            for (int k = 0; k < 5; k++) begin
                g17_b = 1'($urandom_range(0, 1));
                s = crc_bit(s, g17_b);
                @(negedge clk);
            end
            g17_b = 1'b0;
            checks++;
            if (ib.done !== 1'b1 || ib.signature !== s) begin
                errors++;
                $display("FAIL misr_random run=%0d sig=%h done=%0b want=%h done=1", r, ib.signature, ib.done, s);
            end
        end
    endtask

    task automatic test_single_capture;
        @(negedge clk);
        ic.start = 1'b1;
        g17_c = 1'b1;
        @(negedge clk);
        ic.start = 1'b0;
        @(negedge clk);
        g17_c = 1'b0;
        checks++;
        if (ic.done !== 1'b1 || ic.signature !== 16'h1021) begin
            errors++;
            $display("FAIL single_capture sig=%h done=%0b want=1021 done=1", ic.signature, ic.done);
        end
    endtask

    task automatic test_golden;
        int cyc;
        logic [15:0] s;
        launch_a(1'b0);
        wait_done_a(cyc);
        checks++;
        if (ia.signature !== GOLDEN || cyc != 67 || ia.pass !== exp_pass(GOLDEN)) begin
            errors++;
            $display("FAIL golden sig=%h cyc=%0d pass=%0b want=%h 67 %0b", ia.signature, cyc, ia.pass, GOLDEN, exp_pass(GOLDEN));
        end
        s = ia.signature;
        repeat (3) @(negedge clk);
        checks++;
        if (ia.done !== 1'b1 || ia.busy !== 1'b0 || ia.signature !== s) begin
            errors++;
            $display("FAIL done_frozen sig=%h done=%0b want=%h done=1", ia.signature, ia.done, s);
        end
    endtask

    task automatic test_flip;
        int cyc;
        int j;
        logic [15:0] r;
        j = int'($urandom_range(0, 63));
        r = golden_sig(64, j);
        launch_a(1'b0);
        repeat (3 + j) @(negedge clk);
        flip_a = 1'b1;
        @(negedge clk);
        flip_a = 1'b0;
        wait_done_a(cyc);
        checks++;
        if (ia.signature !== r || ia.signature === GOLDEN || ia.pass !== exp_pass(r)) begin
            errors++;
            $display("FAIL flip idx=%0d sig=%h pass=%0b want=%h pass=%0b", j, ia.signature, ia.pass, r, exp_pass(r));
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        launch_a(1'b0);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ia.busy, ia.done, ia.pass, ia.signature, ga3, ga2, ga1, ga0} !== 23'h0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=0", {ia.busy, ia.done, ia.pass, ia.signature, ga3, ga2, ga1, ga0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch_a(1'b0);
        wait_done_a(cyc);
        checks++;
        if (ia.signature !== GOLDEN) begin
            errors++;
            $display("FAIL rerun_after_reset sig=%h want=%h", ia.signature, GOLDEN);
        end
    endtask

    task automatic test_start_ignored;
        int cyc;
        launch_a(1'b0);
        repeat (20) @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        wait_done_a(cyc);
        checks++;
        if (ia.signature !== GOLDEN || cyc != 46) begin
            errors++;
            $display("FAIL start_ignored sig=%h cyc=%0d want=%h 46", ia.signature, cyc, GOLDEN);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [15:0] s1;
        launch_a(1'b1);
        wait_done_a(cyc);
        s1 = ia.signature;
        @(negedge clk);
        checks++;
        if (ia.busy !== 1'b1 || ia.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_one_done busy=%0b done=%0b want busy=1 done=0", ia.busy, ia.done);
        end
        model_rst_n = 1'b0;
        @(negedge clk);
        model_rst_n = 1'b1;
        ia.start = 1'b0;
        wait_done_a(cyc);
        checks++;
        if (s1 !== GOLDEN || ia.signature !== s1 || cyc != 67) begin
            errors++;
            $display("FAIL b2b_sig first=%h second=%h cyc=%0d want=%h 67", s1, ia.signature, cyc, GOLDEN);
        end
    endtask

    initial begin
        test_reset;
        test_lfsr_sequence;
        test_misr_random;
        test_single_capture;
        test_golden;
        test_flip;
        test_reset_mid_run;
        test_start_ignored;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
